hexload_ctl: RTL and testbench

Load-session controller between the Intel HEX receiver and the shared memory write port. Turns the receiver's byte write strobes into a CPU-hold / memory-write / CPU-restart sequence. Buffers bytes in a small FIFO while it waits for the bus, and detects end of load by inactivity timeout. On a clean load it pulses CPU reset; on a receiver error it reports the failure.

---
 rtl/hexload_ctl.sv | 223 ++++++++++++++++++++++
 tb/tb_hexload_ctl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hexload_ctl.sv
// Load-session controller: buffers HEX receiver bytes in a small FIFO, holds the CPU off the bus,
// writes the bytes to memory, then restarts the CPU once the load has gone quiet.
module hexload_ctl #(
    parameter int FIFO_AW      = 2,
    parameter int IDLE_TIMEOUT = 1000000,
    parameter int RESET_LEN    = 16
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        ce_i,
    input  logic        hex_wr_i,
    input  logic [21:0] hex_addr_i,
    input  logic [7:0]  hex_data_i,
    input  logic        hex_error_i,
    output logic        hold_req_o,
    input  logic        hold_ack_i,
    output logic        cpu_reset_o,
    output logic        mem_req_o,
    output logic [21:0] mem_addr_o,
    output logic [7:0]  mem_data_o,
    input  logic        mem_ack_i,
    output logic        loading_o,
    output logic        err_o,
    output logic        overflow_o,
    output logic [15:0] nbytes_o
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int IW    = $clog2(IDLE_TIMEOUT + 1);
    localparam int RW    = $clog2(RESET_LEN + 1);

    localparam logic [CW-1:0]      FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0]      CNT_ONE    = CW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [IW-1:0]      IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0]      IDLE_ONE   = IW'(1);
    localparam logic [RW-1:0]      RESET_LAST = RW'(RESET_LEN - 1);
    localparam logic [RW-1:0]      RESET_ONE  = RW'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HOLD_WAIT = 3'd1;
    localparam logic [2:0] S_ACTIVE    = 3'd2;
    localparam logic [2:0] S_DRAIN     = 3'd3;
    localparam logic [2:0] S_RESET     = 3'd4;

    logic [2:0]         state_q,     state_d;
    logic [FIFO_AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]      count_q,     count_d;
    logic [IW-1:0]      idle_cnt_q,  idle_cnt_d;
    logic [RW-1:0]      rst_cnt_q,   rst_cnt_d;
    logic               granted_q,   granted_d;
    logic               mem_req_q,   mem_req_d;
    logic [21:0]        mem_addr_q,  mem_addr_d;
    logic [7:0]         mem_data_q,  mem_data_d;
    logic               err_q,       err_d;
    logic               overflow_q,  overflow_d;
    logic [15:0]        nbytes_q,    nbytes_d;
    logic               hold_req_q,  hold_req_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               loading_q,   loading_d;

    logic [21:0] fifo_addr [DEPTH];
    logic [7:0]  fifo_data [DEPTH];

    logic fifo_empty, fifo_full, accept, pop, push, can_write;

    // Strobes are taken while a session can still accept bytes; DRAIN and RESET drop them silently.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign accept     = hex_wr_i &&
                        (state_q == S_IDLE || state_q == S_HOLD_WAIT || state_q == S_ACTIVE);
    assign pop        = mem_req_q && mem_ack_i;
    assign push       = accept && (!fifo_full || pop);
    // A DRAIN entered straight from HOLD_WAIT must still wait for the bus before writing.
    assign can_write  = (state_q == S_ACTIVE) || (state_q == S_DRAIN && granted_q);

    always_comb begin
        // NOTE: every _d signal gets a default before any branch so no path infers a latch.
        state_d     = state_q;
        idle_cnt_d  = '0;
        rst_cnt_d   = rst_cnt_q;
        granted_d   = granted_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        err_d       = err_q;
        overflow_d  = overflow_q || (accept && fifo_full && !pop);
        nbytes_d    = nbytes_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d     = count_q;

        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        // A raised request holds its entry until acked; the next one rises a cycle after the drop.
        if (pop) begin
            mem_req_d = 1'b0;
            if (nbytes_q != 16'hFFFF) begin
                nbytes_d = nbytes_q + 16'd1;
            end
        end else if (!mem_req_q && !fifo_empty && can_write) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fifo_addr[rd_ptr_q];
            mem_data_d = fifo_data[rd_ptr_q];
        end

        case (state_q)
            S_IDLE: begin
                if (hex_wr_i) begin
                    state_d    = S_HOLD_WAIT;
                    err_d      = 1'b0;
                    overflow_d = 1'b0;
                    nbytes_d   = '0;
                    granted_d  = 1'b0;
                end
            end
            S_HOLD_WAIT: begin
                if (hex_error_i) begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end else if (hold_ack_i) begin
                    granted_d = 1'b1;
                    state_d   = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!hex_wr_i && fifo_empty) begin
                    idle_cnt_d = idle_cnt_q + IDLE_ONE;
                end
                if (hex_error_i) begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end else if (!hex_wr_i && fifo_empty && idle_cnt_q == IDLE_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = S_RESET;
                end
            end
            S_DRAIN: begin
                if (hold_ack_i) begin
                    granted_d = 1'b1;
                end
                if (fifo_empty && !mem_req_q) begin
                    state_d = S_IDLE;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RESET_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RESET_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        hold_req_d  = (state_d == S_HOLD_WAIT) || (state_d == S_ACTIVE) || (state_d == S_DRAIN);
        cpu_reset_d = (state_d == S_RESET);
        loading_d   = (state_d != S_IDLE);
    end

    // NOTE: the FIFO storage has no reset; the pointers and count reset, so stale entries are never read.
    always_ff @(posedge clk_i) begin
        if (ce_i && push) begin
            fifo_addr[wr_ptr_q] <= hex_addr_i;
            fifo_data[wr_ptr_q] <= hex_data_i;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            idle_cnt_q  <= '0;
            rst_cnt_q   <= '0;
            granted_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            err_q       <= 1'b0;
            overflow_q  <= 1'b0;
            nbytes_q    <= '0;
            hold_req_q  <= 1'b0;
            cpu_reset_q <= 1'b0;
            loading_q   <= 1'b0;
        end else if (ce_i) begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            idle_cnt_q  <= idle_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            granted_q   <= granted_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            err_q       <= err_d;
            overflow_q  <= overflow_d;
            nbytes_q    <= nbytes_d;
            hold_req_q  <= hold_req_d;
            cpu_reset_q <= cpu_reset_d;
            loading_q   <= loading_d;
        end
    end

    assign hold_req_o  = hold_req_q;
    assign cpu_reset_o = cpu_reset_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;
    assign loading_o   = loading_q;
    assign err_o       = err_q;
    assign overflow_o  = overflow_q;
    assign nbytes_o    = nbytes_q;

endmodule

// File: tb/tb_hexload_ctl.sv
// Directed bench for hexload_ctl: clean load, back-pressure, receiver error, slow memory,
// reset during a write, and a clean load with ce_i at one third rate.
module tb_hexload_ctl;
    localparam int IDLE_TO = 8;
    localparam int RST_LEN = 16;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        ce_i;
    logic        hex_wr_i;
    logic [21:0] hex_addr_i;
    logic [7:0]  hex_data_i;
    logic        hex_error_i;
    logic        hold_req_o;
    logic        hold_ack_i;
    logic        cpu_reset_o;
    logic        mem_req_o;
    logic [21:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic        mem_ack_i;
    logic        loading_o;
    logic        err_o;
    logic        overflow_o;
    logic [15:0] nbytes_o;

    hexload_ctl #(
        .FIFO_AW      (2),
        .IDLE_TIMEOUT (IDLE_TO),
        .RESET_LEN    (RST_LEN)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .ce_i        (ce_i),
        .hex_wr_i    (hex_wr_i),
        .hex_addr_i  (hex_addr_i),
        .hex_data_i  (hex_data_i),
        .hex_error_i (hex_error_i),
        .hold_req_o  (hold_req_o),
        .hold_ack_i  (hold_ack_i),
        .cpu_reset_o (cpu_reset_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_ack_i   (mem_ack_i),
        .loading_o   (loading_o),
        .err_o       (err_o),
        .overflow_o  (overflow_o),
        .nbytes_o    (nbytes_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int ce_gap = 0;
    int ack_lat = 1;
    int req_run = 0;
    int last_req_len = 0;
    logic [21:0] cap_addr;
    logic [7:0]  cap_data;
    logic [29:0] wr_log [$];

    int   sess_rst_hi;
    int   sess_gap;
    int   sess_bad_hold;
    logic sess_fall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One ce_i cycle; afterwards the memory responder reacts to the updated outputs.
    task automatic cyc();
        logic        p_req;
        logic        p_ack;
        logic [21:0] p_addr;
        logic [7:0]  p_data;
        p_req  = mem_req_o;
        p_ack  = mem_ack_i;
        p_addr = mem_addr_o;
        p_data = mem_data_o;
        for (int k = 0; k < ce_gap; k++) begin
            ce_i = 1'b0;
            @(negedge clk_i);
        end
        ce_i = 1'b1;
        @(negedge clk_i);
        if (p_ack && p_req) begin
            wr_log.push_back({p_addr, p_data});
            last_req_len = req_run;
            req_run = 0;
            check("req_drop_after_ack", mem_req_o, 1'b0);
        end
        mem_ack_i = 1'b0;
        if (mem_req_o) begin
            if (!p_req) begin
                req_run  = 1;
                cap_addr = mem_addr_o;
                cap_data = mem_data_o;
            end else begin
                req_run++;
                check("req_stable", {2'b0, mem_addr_o, mem_data_o}, {2'b0, cap_addr, cap_data});
            end
            if (req_run >= ack_lat) mem_ack_i = 1'b1;
        end
    endtask

    task automatic send(input logic [21:0] a, input logic [7:0] d);
        hex_wr_i   = 1'b1;
        hex_addr_i = a;
        hex_data_i = d;
        cyc();
        hex_wr_i   = 1'b0;
    endtask

    // Runs until loading_o falls, measuring timeout distance, reset pulse length and hold_req gaps.
    task automatic run_session();
        int   n;
        int   last_wr;
        int   first_rst;
        int   sz;
        logic prev_rst;
        n = 0; last_wr = 0; first_rst = -1; prev_rst = 1'b0;
        sess_rst_hi = 0; sess_bad_hold = 0;
        while (loading_o === 1'b1 && n < 400) begin
            prev_rst = cpu_reset_o;
            sz = wr_log.size();
            cyc();
            n++;
            if (wr_log.size() != sz) last_wr = n;
            if (cpu_reset_o) begin
                sess_rst_hi++;
                if (first_rst < 0) first_rst = n;
                if (hold_req_o) sess_bad_hold++;
            end else if (loading_o && !hold_req_o) begin
                sess_bad_hold++;
            end
        end
        check("session_ends", (n < 400), 1'b1);
        sess_gap  = (first_rst < 0) ? -1 : first_rst - last_wr;
        sess_fall = prev_rst && !cpu_reset_o;
    endtask

    task automatic clean_load(input string t);
        wr_log.delete();
        ack_lat    = 1;
        hold_ack_i = 1'b0;
        send(22'h000100, 8'hAA);
        check({t, ":hold_req_next"}, {hold_req_o, loading_o, mem_req_o}, 3'b110);
        send(22'h000101, 8'hBB);
        send(22'h000102, 8'hCC);
        cyc();
        cyc();
        hold_ack_i = 1'b1;
        cyc();
        check({t, ":no_req_at_ack"}, mem_req_o, 1'b0);
        cyc();
        check({t, ":first_req"}, {1'b1, mem_req_o, mem_addr_o, mem_data_o}, {2'b11, 22'h000100, 8'hAA});
        cyc();
        check({t, ":drop_and_count"}, {mem_req_o, nbytes_o}, {1'b0, 16'd1});
        run_session();
        check({t, ":nwrites"}, wr_log.size(), 3);
        if (wr_log.size() >= 3) begin
            check({t, ":wr0"}, wr_log[0], {22'h000100, 8'hAA});
            check({t, ":wr1"}, wr_log[1], {22'h000101, 8'hBB});
            check({t, ":wr2"}, wr_log[2], {22'h000102, 8'hCC});
        end
        check({t, ":nbytes"}, nbytes_o, 16'd3);
        check({t, ":timeout_gap"}, sess_gap, IDLE_TO);
        check({t, ":reset_len"}, sess_rst_hi, RST_LEN);
        check({t, ":loading_falls_with_reset"}, sess_fall, 1'b1);
        check({t, ":hold_pattern"}, sess_bad_hold, 0);
        check({t, ":flags"}, {err_o, overflow_o, hold_req_o}, 3'b000);
        hold_ack_i = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        ce_i        = 1'b0;
        hex_wr_i    = 1'b0;
        hex_addr_i  = '0;
        hex_data_i  = '0;
        hex_error_i = 1'b0;
        hold_ack_i  = 1'b0;
        mem_ack_i   = 1'b0;
        #1;
        check("reset_ctl", {hold_req_o, cpu_reset_o, mem_req_o, loading_o, err_o, overflow_o}, 6'b0);
        check("reset_bus", {2'b0, mem_addr_o, mem_data_o}, 32'h0);
        check("reset_nbytes", nbytes_o, 16'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        cyc();
        check("idle_after_reset", loading_o, 1'b0);

        clean_load("clean");

        // Back-pressure: six strobes while the bus is withheld for 50 cycles.
        wr_log.delete();
        for (int i = 0; i < 6; i++) begin
            send(22'(22'h000300 + i), 8'(8'h10 + i));
            if (i == 3) check("bp_full_no_ovf", overflow_o, 1'b0);
        end
        check("bp_ovf", {overflow_o, mem_req_o, hold_req_o}, 3'b101);
        repeat (44) cyc();
        hold_ack_i = 1'b1;
        run_session();
        check("bp_nwrites", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_log.size()) check("bp_wr", wr_log[i], {22'(22'h000300 + i), 8'(8'h10 + i)});
        end
        check("bp_nbytes", nbytes_o, 16'd4);
        check("bp_ovf_sticky", overflow_o, 1'b1);
        check("bp_reset_len", sess_rst_hi, RST_LEN);
        hold_ack_i = 1'b0;

        // Receiver error with one write in flight and one queued.
        wr_log.delete();
        ack_lat    = 4;
        hold_ack_i = 1'b1;
        send(22'h000200, 8'h11);
        send(22'h000201, 8'h22);
        cyc();
        hex_error_i = 1'b1;
        cyc();
        hex_error_i = 1'b0;
        check("err_set", {err_o, mem_req_o, hold_req_o, cpu_reset_o}, 4'b1110);
        run_session();
        check("err_nwrites", wr_log.size(), 2);
        if (wr_log.size() >= 2) check("err_wr1", wr_log[1], {22'h000201, 8'h22});
        check("err_no_cpu_reset", sess_rst_hi, 0);
        check("err_hold_kept", sess_bad_hold, 0);
        check("err_end", {err_o, hold_req_o, nbytes_o}, {1'b1, 1'b0, 16'd2});
        hold_ack_i = 1'b0;
        ack_lat    = 1;
        cyc();
        check("err_sticky", err_o, 1'b1);
        send(22'h000210, 8'h33);
        check("err_cleared", {err_o, loading_o, nbytes_o}, {1'b0, 1'b1, 16'd0});
        hold_ack_i = 1'b1;
        run_session();
        check("err_next_session", {err_o, nbytes_o}, {1'b0, 16'd1});
        check("err_next_reset_len", sess_rst_hi, RST_LEN);
        hold_ack_i = 1'b0;

        // Slow memory, plus an ack offered while no request is up.
        wr_log.delete();
        ack_lat = 10;
        send(22'h2A5A5, 8'h5A);
        hold_ack_i = 1'b1;
        cyc();
        mem_ack_i = 1'b1;
        cyc();
        check("slow_stray_ack", {mem_req_o, nbytes_o}, {1'b1, 16'd0});
        run_session();
        check("slow_nwrites", wr_log.size(), 1);
        if (wr_log.size() >= 1) check("slow_wr", wr_log[0], {22'h2A5A5, 8'h5A});
        check("slow_req_len", last_req_len, 10);
        check("slow_nbytes", nbytes_o, 16'd1);
        hold_ack_i = 1'b0;
        ack_lat    = 1;

        // Asynchronous reset while a write is outstanding.
        wr_log.delete();
        ack_lat    = 1000;
        hold_ack_i = 1'b1;
        send(22'h000123, 8'h77);
        cyc();
        cyc();
        check("rst_req_pending", mem_req_o, 1'b1);
        ce_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_ctl", {hold_req_o, cpu_reset_o, mem_req_o, loading_o, err_o, overflow_o}, 6'b0);
        check("rst_async_bus", {2'b0, mem_addr_o, mem_data_o, nbytes_o[7:0]}, 32'h0);
        hold_ack_i = 1'b0;
        mem_ack_i  = 1'b0;
        req_run    = 0;
        ack_lat    = 1;
        @(negedge clk_i);
        rst_n = 1'b1;
        cyc();
        send(22'h000124, 8'h78);
        check("rst_fresh", {loading_o, hold_req_o, nbytes_o}, {2'b11, 16'd0});
        hold_ack_i = 1'b1;
        run_session();
        check("rst_nwrites", wr_log.size(), 1);
        if (wr_log.size() >= 1) check("rst_wr", wr_log[0], {22'h000124, 8'h78});
        check("rst_nbytes", nbytes_o, 16'd1);
        hold_ack_i = 1'b0;

        ce_gap = 2;
        clean_load("ce3");
        ce_gap = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
